// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set bit of r when scanning ptr, ptr+1, ... with wrap-around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2_4 (
    input  logic       x0,
    input  logic       x1,
    input  logic       e,
    output logic [3:0] y
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        y = 4'b0000;
        if (e) begin
            y[{x1, x0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-holder hold limit;
// grant index/valid are registered, the one-hot grant is a pure decode of them.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int              CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] winner;
    logic             timeout;
    logic             keep;

    always_comb begin
        others  = req & ~(N_REQ'(1) << gnt_idx);
        // In IDLE nobody holds, so every request is a candidate.
        cand    = (state == GRANT) ? others : req;
        winner  = rr_pick(cand, ptr);
        timeout = (hold_cnt == HOLD_LAST) && (others != '0);
        keep    = en && req[gnt_idx] && !timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (en && (req != '0)) begin
                        state     <= GRANT;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        ptr       <= winner + 1'b1;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                    end else if (keep) begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (others != '0) begin
                        // Back-to-back handover; ptr already points past the holder.
                        gnt_idx  <= winner;
                        hold_cnt <= '0;
                        ptr      <= winner + 1'b1;
                    end else begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder_2_4 u_dec (
        .x0 (gnt_idx[0]),
        .x1 (gnt_idx[1]),
        .e  (gnt_valid),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed-vector bench for rr_arbiter_4 with HOLD_MAX=4.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_vec  = 0;
    int n_miss = 0;

    rr_arbiter_4 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with the given request pattern, then release on a falling edge.
    task automatic restart(input logic [3:0] r);
        rst_n = 1'b0;
        en    = 1'b1;
        req   = r;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;

        // Reset state while requests are pending
        #3;
        check("rst_gnt",   gnt,       4'b0000);
        check("rst_valid", gnt_valid, 1'b0);
        check("rst_idx",   gnt_idx,   2'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
        step();
        check("first_gnt",   gnt,       4'b0001);
        check("first_valid", gnt_valid, 1'b1);

        // Round-robin: each holder keeps 2 cycles then drops, no idle gap
        restart(4'b1111);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_first_%0d", k), gnt, 4'b0001 << order[k]);
            check($sformatf("rr_valid_%0d", k), gnt_valid, 1'b1);
            req = 4'b1111;
            step();
            check($sformatf("rr_second_%0d", k), gnt, 4'b0001 << order[k]);
            req = 4'b1111 & ~(4'b0001 << order[k]);
            step();
        end

        // Timeout: two steady requesters alternate every HOLD_MAX cycles
        restart(4'b0011);
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("to_cyc%0d", c), gnt,
                  (c <= 4) ? 4'b0001 : (c <= 8) ? 4'b0010 : 4'b0001);
        end

        // Saturation: sole requester keeps the grant indefinitely
        restart(4'b0100);
        for (int c = 1; c <= 50; c++) begin
            step();
            check($sformatf("sat_cyc%0d", c), gnt, 4'b0100);
        end
        req = 4'b0101;
        step();
        check("sat_handover", gnt, 4'b0001);
        check("sat_idx",      gnt_idx, 2'd0);

        // Enable drop mid-grant keeps ptr; re-enable resumes after holder
        restart(4'b0010);
        step();
        check("en_pre_gnt", gnt, 4'b0010);
        en = 1'b0;
        step();
        check("en_off_gnt",   gnt,       4'b0000);
        check("en_off_valid", gnt_valid, 1'b0);
        check("en_off_idx",   gnt_idx,   2'd1);
        step();
        check("en_off_stay", gnt, 4'b0000);
        en  = 1'b1;
        req = 4'b1111;
        step();
        check("en_resume", gnt, 4'b0100);

        // Asynchronous reset mid-grant, ptr back to 0
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   gnt,       4'b0000);
        check("async_rst_valid", gnt_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", gnt, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
